// File: rtl/led_status_ctrl.sv
// rtl/led_status_ctrl.sv - multi-channel LED driver with on/off, shared slow/fast blink and per-channel burst patterns
module led_status_ctrl #(
  parameter int N_LED      = 6,
  parameter int SLOW_HALF  = 25_000_000,
  parameter int FAST_HALF  = 6_250_000,
  parameter int GAP_LEN    = 50_000_000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [3*N_LED-1:0] mode,
  input  logic [4*N_LED-1:0] count,
  output logic [N_LED-1:0]   led
);

  localparam logic [2:0] MODE_OFF   = 3'd0;
  localparam logic [2:0] MODE_ON    = 3'd1;
  localparam logic [2:0] MODE_SLOW  = 3'd2;
  localparam logic [2:0] MODE_FAST  = 3'd3;
  localparam logic [2:0] MODE_BURST = 3'd4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_PULSE_ON  = 2'd1;
  localparam logic [1:0] ST_PULSE_OFF = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  localparam int SW = (SLOW_HALF > 1) ? $clog2(SLOW_HALF) : 1;
  localparam int FW = (FAST_HALF > 1) ? $clog2(FAST_HALF) : 1;
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  // One per-channel cycle counter covers both pulse halves and the gap.
  localparam int CW = (FW > GW) ? FW : GW;

  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_HALF - 1);
  localparam logic [FW-1:0] FAST_LAST = FW'(FAST_HALF - 1);
  localparam logic [CW-1:0] PULSE_END = CW'(FAST_HALF - 1);
  localparam logic [CW-1:0] GAP_END   = CW'(GAP_LEN - 1);

  logic [SW-1:0]    slow_cnt_q, slow_cnt_d;
  logic [FW-1:0]    fast_cnt_q, fast_cnt_d;
  logic             slow_ph_q, slow_ph_d;
  logic             fast_ph_q, fast_ph_d;
  logic [N_LED-1:0] led_q, led_d;

  // Free-running shared blink timebases so every blinking channel stays in lockstep.
  always_comb begin
    slow_cnt_d = slow_cnt_q + SW'(1);
    slow_ph_d  = slow_ph_q;
    if (slow_cnt_q == SLOW_LAST) begin
      slow_cnt_d = '0;
      slow_ph_d  = ~slow_ph_q;
    end
    fast_cnt_d = fast_cnt_q + FW'(1);
    fast_ph_d  = fast_ph_q;
    if (fast_cnt_q == FAST_LAST) begin
      fast_cnt_d = '0;
      fast_ph_d  = ~fast_ph_q;
    end
  end

  // Timebase and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slow_cnt_q <= '0;
      fast_cnt_q <= '0;
      slow_ph_q  <= 1'b0;
      fast_ph_q  <= 1'b0;
      led_q      <= {N_LED{ACTIVE_LOW}};
    end else begin
      slow_cnt_q <= slow_cnt_d;
      fast_cnt_q <= fast_cnt_d;
      slow_ph_q  <= slow_ph_d;
      fast_ph_q  <= fast_ph_d;
      led_q      <= led_d;
    end
  end

  assign led = led_q;

  for (genvar i = 0; i < N_LED; i++) begin : g_ch
    logic [2:0]    ch_mode;
    logic [3:0]    ch_count;
    logic [2:0]    mode_hist_q;
    logic [3:0]    count_hist_q;
    logic [1:0]    st_q, st_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [3:0]    pc_q, pc_d;
    logic          changed;
    logic          ch_lg;

    assign ch_mode  = mode[3*i +: 3];
    assign ch_count = count[4*i +: 4];
    assign changed  = (ch_mode != mode_hist_q) || (ch_count != count_hist_q);

    // Burst sequencer; any setting change parks it in IDLE so the burst restarts cleanly.
    always_comb begin
      st_d  = st_q;
      cyc_d = cyc_q + CW'(1);
      pc_d  = pc_q;
      if (changed || (ch_mode != MODE_BURST)) begin
        st_d  = ST_IDLE;
        cyc_d = '0;
      end else begin
        case (st_q)
          ST_IDLE: begin
            cyc_d = '0;
            if (ch_count != 4'd0) begin
              st_d = ST_PULSE_ON;
              pc_d = ch_count;
            end
          end
          ST_PULSE_ON: begin
            if (cyc_q == PULSE_END) begin
              st_d  = ST_PULSE_OFF;
              cyc_d = '0;
            end
          end
          ST_PULSE_OFF: begin
            if (cyc_q == PULSE_END) begin
              cyc_d = '0;
              pc_d  = pc_q - 4'd1;
              st_d  = (pc_q == 4'd1) ? ST_GAP : ST_PULSE_ON;
            end
          end
          default: begin
            if (cyc_q == GAP_END) begin
              cyc_d = '0;
              if (ch_count == 4'd0) begin
                st_d = ST_IDLE;
              end else begin
                st_d = ST_PULSE_ON;
                pc_d = ch_count;
              end
            end
          end
        endcase
      end
    end

    // Logical LED level for the value this channel will hold after the coming edge.
    always_comb begin
      ch_lg = 1'b0;
      case (ch_mode)
        MODE_OFF:   ch_lg = 1'b0;
        MODE_ON:    ch_lg = 1'b1;
        MODE_SLOW:  ch_lg = slow_ph_d;
        MODE_FAST:  ch_lg = fast_ph_d;
        MODE_BURST: ch_lg = (st_d == ST_PULSE_ON);
        default:    ch_lg = 1'b0;
      endcase
    end

    assign led_d[i] = ch_lg ^ ACTIVE_LOW;

    // Per-channel sequencer state and input history.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        mode_hist_q  <= '0;
        count_hist_q <= '0;
        st_q         <= ST_IDLE;
        cyc_q        <= '0;
        pc_q         <= '0;
      end else begin
        mode_hist_q  <= ch_mode;
        count_hist_q <= ch_count;
        st_q         <= st_d;
        cyc_q        <= cyc_d;
        pc_q         <= pc_d;
      end
    end
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// tb/tb_led_status_ctrl.sv - scoreboard bench for led_status_ctrl
module tb_led_status_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] mode = '0;
  logic [11:0] mode2 = '0;
  logic [15:0] count = '0;
  logic [3:0]  led;
  logic [3:0]  led2;

  typedef struct {
    logic [3:0] e1;
    logic [3:0] e2;
    int         sc;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  led_status_ctrl #(
    .N_LED(4), .SLOW_HALF(8), .FAST_HALF(2), .GAP_LEN(10), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .count(count), .led(led)
  );

  led_status_ctrl #(
    .N_LED(4), .SLOW_HALF(8), .FAST_HALF(2), .GAP_LEN(10), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .reset(reset), .mode(mode2), .count(count), .led(led2)
  );

  always #5 clk = ~clk;

  // Expected burst output (count=3) after edge e, counting edge 0 as the first after the setting appears.
  function automatic logic burst3(input int e);
    int k;
    if (e < 1) return 1'b0;
    k = (e - 1) % 22;
    return (k < 12) && ((k % 4) < 2);
  endfunction

  function automatic logic slow_exp(input int e);
    return ((e + 1) / 8) % 2 == 1;
  endfunction

  function automatic logic fast_exp(input int e);
    return ((e + 1) / 2) % 2 == 1;
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] e1, input logic [3:0] e2, input int sc, input int cyc);
    exp_t x;
    x.e1 = e1; x.e2 = e2; x.sc = sc; x.cyc = cyc;
    exp_q.push_back(x);
  endtask

  // Reset with new settings; returns at the negedge just before edge 0 with reset released.
  task automatic do_reset(input logic [11:0] m, input logic [15:0] c, input logic [11:0] m2);
    @(negedge clk);
    reset = 1'b1;
    mode = m; count = c; mode2 = m2;
    repeat (2) @(negedge clk);
    check("reset_led", led, 4'b0000);
    check("reset_led_al", led2, 4'b1111);
    reset = 1'b0;
  endtask

  // Monitor: every cycle the DUT presents a registered LED value, compare against the queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        checks++;
        if (led !== x.e1) begin
          errors++;
          $display("FAIL sc%0d cyc%0d led actual=%b required=%b", x.sc, x.cyc, led, x.e1);
        end
        checks++;
        if (led2 !== x.e2) begin
          errors++;
          $display("FAIL sc%0d cyc%0d led_al actual=%b required=%b", x.sc, x.cyc, led2, x.e2);
        end
      end
    end
  end

  initial begin
    // Scenario 1: all channels off.
    do_reset(12'd0, 16'd0, 12'd0);
    for (int e = 0; e < 20; e++) begin
      if (e != 0) @(negedge clk);
      push(4'b0000, 4'b1111, 1, e);
    end

    // Scenario 2: ch0 ON, ch1 SLOW, ch2 FAST.
    do_reset({3'd0, 3'd3, 3'd2, 3'd1}, 16'd0, 12'd0);
    for (int e = 0; e < 40; e++) begin
      if (e != 0) @(negedge clk);
      push({1'b0, fast_exp(e), slow_exp(e), 1'b1}, 4'b1111, 2, e);
    end

    // Scenario 3: ch3 burst of 3.
    do_reset({3'd4, 3'd0, 3'd0, 3'd0}, 16'h3000, 12'd0);
    for (int e = 0; e < 50; e++) begin
      if (e != 0) @(negedge clk);
      push({burst3(e), 3'b000}, 4'b1111, 3, e);
    end

    // Scenario 4: count 3->1 during second pulse.
    do_reset({3'd4, 3'd0, 3'd0, 3'd0}, 16'h3000, 12'd0);
    for (int e = 0; e < 40; e++) begin
      logic b;
      if (e != 0) @(negedge clk);
      if (e == 6) count = 16'h1000;
      if (e < 6) b = burst3(e);
      else if (e == 6) b = 1'b0;
      else b = ((e - 7) % 14) < 2;
      push({b, 3'b000}, 4'b1111, 4, e);
    end

    // Scenario 5: burst with count 0, reserved mode codes; ACTIVE_LOW copy has ch0 ON.
    do_reset({3'd4, 3'd7, 3'd6, 3'd5}, 16'h0000, {3'd0, 3'd0, 3'd0, 3'd1});
    for (int e = 0; e < 30; e++) begin
      if (e != 0) @(negedge clk);
      push(4'b0000, 4'b1110, 5, e);
    end

    // Scenario 6: asynchronous reset during a pulse, then burst restarts.
    do_reset({3'd4, 3'd0, 3'd0, 3'd0}, 16'h3000, 12'd0);
    for (int e = 0; e < 10; e++) begin
      if (e != 0) @(negedge clk);
      push({burst3(e), 3'b000}, 4'b1111, 6, e);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_led", led, 4'b0000);
    check("async_reset_led_al", led2, 4'b1111);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < 30; e++) begin
      if (e != 0) @(negedge clk);
      push({burst3(e), 3'b000}, 4'b1111, 7, e);
    end

    repeat (3) @(posedge clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
LED_STATUS_CTRL -- requirements
Module: led_status_ctrl

Interface
REQ-001 Parameter N_LED, default 6: number of independent LED channels, range 1..16.
REQ-002 Parameter SLOW_HALF, default 25_000_000: slow-blink half-period in clk cycles, minimum 2.
REQ-003 Parameter FAST_HALF, default 6_250_000: fast-blink and burst-pulse half-period in clk cycles, minimum 2.
REQ-004 Parameter GAP_LEN, default 50_000_000: burst inter-group gap in clk cycles, minimum 2.
REQ-005 Parameter ACTIVE_LOW, default 0: 1 inverts every led bit at the output.
REQ-006 clk  input  1  sole clock; all logic on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 mode  input  3*N_LED  per-channel mode; channel i uses bits [3i+2:3i].
REQ-009 count  input  4*N_LED  per-channel burst pulse count; channel i uses bits [4i+3:4i].
REQ-010 led  output  N_LED  registered LED drive, one bit per channel.

Function
REQ-011 Mode codes SHALL be: 0 OFF, 1 ON, 2 SLOW, 3 FAST, 4 BURST, 5..7 treated as OFF.
REQ-012 Logical on/off SHALL be computed per channel; led[i] = logical value XOR ACTIVE_LOW, registered.
REQ-013 OFF/ON SHALL drive logical 0/1 with one-cycle latency from mode change.
REQ-014 Global slow counter SHALL count 0..SLOW_HALF-1 and wrap; slow phase toggles at wrap; starts at 0, phase 0 after reset.
REQ-015 Global fast counter SHALL count 0..FAST_HALF-1 and wrap; fast phase toggles at wrap; phase 0 after reset.
REQ-016 SLOW/FAST channels SHALL output the global slow/fast phase registered, so all channels in the same mode blink in lockstep.
REQ-017 Global counters SHALL run free regardless of channel modes.
REQ-018 Each channel SHALL have a private burst FSM with states IDLE, PULSE_ON, PULSE_OFF, GAP, a private cycle counter and a 4-bit pulse counter.
REQ-019 IDLE: logical 0; when mode=4 and count!=0, go to PULSE_ON next cycle, load pulse counter with count, clear cycle counter.
REQ-020 PULSE_ON: logical 1 for FAST_HALF cycles, then PULSE_OFF.
REQ-021 PULSE_OFF: logical 0 for FAST_HALF cycles; then decrement pulse counter; if it becomes 0 go to GAP, else PULSE_ON.
REQ-022 GAP: logical 0 for GAP_LEN cycles, then reload pulse counter from current count and go to PULSE_ON; if count=0 at that point go to IDLE.
REQ-023 mode=4 with count=0 SHALL hold the FSM in IDLE (output 0).
REQ-024 Any change of a channel's mode or count versus the previous cycle SHALL force its FSM to IDLE on the next edge, restarting a burst from PULSE_ON one cycle later.
REQ-025 A mode leaving 4 SHALL force the FSM to IDLE; the FSM SHALL remain in IDLE while mode!=4.
REQ-026 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each follow REQ-024.
REQ-027 Counter widths SHALL be $clog2 of the respective parameter; no counter overflows for any legal parameter value.

Reset
REQ-028 While reset=1: all counters 0, all phases 0, all FSMs IDLE, mode/count history registers 0, led = {N_LED{ACTIVE_LOW}}.
REQ-029 Reset asserted mid-burst or mid-blink SHALL take effect immediately (asynchronously); after deassertion, first clk edge is cycle 0 of REQ-014/015.

Verification (N_LED=4, SLOW_HALF=8, FAST_HALF=2, GAP_LEN=10, ACTIVE_LOW=0 unless stated)
REQ-030 Reset, all modes 0 -> led=4'b0000 throughout; ACTIVE_LOW=1 -> led=4'b1111 during and after reset.
REQ-031 ch0 mode=1, ch1 mode=2, ch2 mode=3 from reset release -> ch0 high after 1 cycle; ch1 period 16 cycles, 50% duty; ch2 period 4 cycles; ch1/ch2 rising edges aligned with counter wraps.
REQ-032 ch3 mode=4, count=3 -> pattern 1,1,0,0 x3 then 10 zeros, repeating with period 22 cycles; first high 2 cycles after mode applied.
REQ-033 ch3 count changed 3->1 during second pulse -> FSM to IDLE next edge, new pattern 1,1,0,0 then 10 zeros, period 14 cycles.
REQ-034 ch3 mode=4, count=0 -> led[3]=0 indefinitely; mode 6 on any channel -> led bit 0.
REQ-035 Reset pulse mid-burst (PULSE_ON) -> led[3]=0 same cycle; burst restarts from PULSE_ON after release.
